// File: rtl/traffic_sensor_cond_pkg.sv
// Shared types and default constants for the traffic-light sensor input stage.
package sensor_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } deb_state_t;

  localparam int CLK_HZ          = 16000000;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int DEB_CYCLES_DEF  = CLK_HZ / 100;
  localparam int TICK_DIV_DEF    = 67108864;

endpackage

// File: rtl/traffic_sensor_cond_if.sv
// Sensor-pin, acknowledge and status signals between the board-level wrapper and the input stage.
interface traffic_sensor_cond_if;
  logic sen_a_n;
  logic sen_b_n;
  logic ack_a;
  logic ack_b;
  logic ta_o;
  logic tb_o;
  logic tick_o;
  logic hb_o;

  modport slave (
    input  sen_a_n, sen_b_n, ack_a, ack_b,
    output ta_o, tb_o, tick_o, hb_o
  );

  modport master (
    output sen_a_n, sen_b_n, ack_a, ack_b,
    input  ta_o, tb_o, tick_o, hb_o
  );
endinterface

// File: rtl/traffic_sensor_cond_debounce_channel.sv
// One sensor channel: pin synchroniser, four-state debounce FSM and, with STICKY_REQ_EN,
// a request latch that is set on the debounced rising edge and cleared by the grant.
module debounce_channel
  import sensor_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DEB_CYCLES  = DEB_CYCLES_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pin_n,
  input  logic i_ack,
  output logic o_out
);

  localparam int             CW       = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  deb_state_t             r_state;
  logic [CW-1:0]          r_cnt;
  logic                   r_level;
  logic                   w_s;
  logic                   w_rise;

  assign w_s = ~r_sync[SYNC_STAGES-1];

  // Debounced level is about to go 0->1 on this edge
  always_comb begin
    w_rise = 1'b0;
    if ((r_state == PRESS_WAIT) && w_s && (r_cnt == CNT_LAST)) begin
      w_rise = 1'b1;
    end else begin
      w_rise = 1'b0;
    end
  end

  // Pin synchroniser; idles at the pulled-up level
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= {SYNC_STAGES{1'b1}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin_n};
    end
  end

  // Debounce FSM: any disagreeing sample restarts the stability window
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= RELEASED;
      r_cnt   <= CNT_ZERO;
      r_level <= 1'b0;
    end else begin
      case (r_state)
        RELEASED: begin
          if (w_s) begin
            r_state <= PRESS_WAIT;
            r_cnt   <= CNT_ONE;
          end
        end
        PRESS_WAIT: begin
          if (!w_s) begin
            r_state <= RELEASED;
            r_cnt   <= CNT_ZERO;
          end else if (w_rise) begin
            r_state <= PRESSED;
            r_cnt   <= CNT_ZERO;
            r_level <= 1'b1;
          end else begin
            r_cnt   <= r_cnt + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!w_s) begin
            r_state <= RELEASE_WAIT;
            r_cnt   <= CNT_ONE;
          end
        end
        RELEASE_WAIT: begin
          if (w_s) begin
            r_state <= PRESSED;
            r_cnt   <= CNT_ZERO;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= RELEASED;
            r_cnt   <= CNT_ZERO;
            r_level <= 1'b0;
          end else begin
            r_cnt   <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_state <= RELEASED;
          r_cnt   <= CNT_ZERO;
          r_level <= 1'b0;
        end
      endcase
    end
  end

`ifdef STICKY_REQ_EN
  logic r_req;

  // Request latch: a new press beats a simultaneous grant
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_req <= 1'b0;
    end else if (w_rise) begin
      r_req <= 1'b1;
    end else if (i_ack) begin
      r_req <= 1'b0;
    end else begin
      r_req <= r_req;
    end
  end

  assign o_out = r_req;
`else
  logic w_unused_ack;

  assign w_unused_ack = i_ack;
  assign o_out        = r_level;
`endif

endmodule

// File: rtl/traffic_sensor_cond.sv
// Input stage for the traffic-light controller: two debounced car sensors, a state-advance
// tick and an LED heartbeat. Define STICKY_REQ_EN to turn ta_o/tb_o into acknowledged requests.
module traffic_sensor_cond
  import sensor_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
  parameter int TICK_DIV    = TICK_DIV_DEF
) (
  input  logic                  CLK,
  input  logic                  reset_n,
  traffic_sensor_cond_if.slave  bus
);

  localparam int             TW     = $clog2(TICK_DIV);
  localparam logic [TW-1:0]  T_ZERO = {TW{1'b0}};
  localparam logic [TW-1:0]  T_ONE  = TW'(1);
  localparam logic [TW-1:0]  T_LAST = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0]  T_HALF = TW'(TICK_DIV / 2);

  logic [TW-1:0] r_tcnt;
  logic [TW-1:0] w_tcnt_nxt;
  logic          r_tick;
  logic          r_hb;

  debounce_channel #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEB_CYCLES  (DEB_CYCLES)
  ) u_chan_a (
    .i_clk   (CLK),
    .i_rst_n (reset_n),
    .i_pin_n (bus.sen_a_n),
    .i_ack   (bus.ack_a),
    .o_out   (bus.ta_o)
  );

  debounce_channel #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEB_CYCLES  (DEB_CYCLES)
  ) u_chan_b (
    .i_clk   (CLK),
    .i_rst_n (reset_n),
    .i_pin_n (bus.sen_b_n),
    .i_ack   (bus.ack_b),
    .o_out   (bus.tb_o)
  );

  // Next period count, wrapping after the last cycle of the period
  always_comb begin
    w_tcnt_nxt = T_ZERO;
    if (r_tcnt == T_LAST) begin
      w_tcnt_nxt = T_ZERO;
    end else begin
      w_tcnt_nxt = r_tcnt + T_ONE;
    end
  end

  // Tick/heartbeat are decoded from the next count so they line up with r_tcnt
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_tcnt <= T_ZERO;
      r_tick <= 1'b0;
      r_hb   <= 1'b0;
    end else begin
      r_tcnt <= w_tcnt_nxt;
      r_tick <= (w_tcnt_nxt == T_LAST);
      r_hb   <= (w_tcnt_nxt >= T_HALF);
    end
  end

  assign bus.tick_o = r_tick;
  assign bus.hb_o   = r_hb;

endmodule

// File: tb/tb_traffic_sensor_cond.sv
// Self-checking bench for traffic_sensor_cond with small parameters; compares against a
// cycle model built from "level flips after DEB consecutive disagreeing samples".
module tb_traffic_sensor_cond;

  localparam int SS   = 2;
  localparam int DEB  = 4;
  localparam int TDIV = 8;

  logic CLK = 1'b0;
  logic reset_n;
  traffic_sensor_cond_if bus ();

  traffic_sensor_cond #(
    .SYNC_STAGES (SS),
    .DEB_CYCLES  (DEB),
    .TICK_DIV    (TDIV)
  ) dut (
    .CLK     (CLK),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  bit m_dly [2][SS];
  int m_run [2];
  bit m_lvl [2];
  bit m_req [2];
  int m_k;

  task automatic model_reset();
    for (int ch = 0; ch < 2; ch++) begin
      for (int j = 0; j < SS; j++) m_dly[ch][j] = 1'b1;
      m_run[ch] = 0;
      m_lvl[ch] = 1'b0;
      m_req[ch] = 1'b0;
    end
    m_k = 0;
  endtask

  function automatic logic [3:0] exp_vec();
`ifdef STICKY_REQ_EN
    return {m_req[0], m_req[1], (m_k == TDIV - 1), (m_k >= TDIV / 2)};
`else
    return {m_lvl[0], m_lvl[1], (m_k == TDIV - 1), (m_k >= TDIV / 2)};
`endif
  endfunction

  function automatic logic [3:0] dut_vec();
    return {bus.ta_o, bus.tb_o, bus.tick_o, bus.hb_o};
  endfunction

  // Advance one clock, update the model from the inputs seen at the edge, return 1 ns later
  task automatic step();
    bit pin [2];
    bit ack [2];
    bit s;
    bit rose;
    @(posedge CLK);
    pin[0] = bus.sen_a_n; pin[1] = bus.sen_b_n;
    ack[0] = bus.ack_a;   ack[1] = bus.ack_b;
    if (!reset_n) begin
      model_reset();
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        s = !m_dly[ch][SS-1];
        for (int j = SS - 1; j > 0; j--) m_dly[ch][j] = m_dly[ch][j-1];
        m_dly[ch][0] = pin[ch];
        rose = 1'b0;
        if (s != m_lvl[ch]) begin
          m_run[ch]++;
          if (m_run[ch] == DEB) begin
            m_lvl[ch] = s;
            m_run[ch] = 0;
            rose = s;
          end
        end else begin
          m_run[ch] = 0;
        end
        if (rose) m_req[ch] = 1'b1;
        else if (ack[ch]) m_req[ch] = 1'b0;
      end
      m_k = (m_k + 1) % TDIV;
    end
    #1;
  endtask

  // Return both channels to idle, clearing any latched request
  task automatic settle();
    bus.sen_a_n = 1'b1; bus.sen_b_n = 1'b1;
    bus.ack_a = 1'b1; bus.ack_b = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL settle cyc %0d got %b want %b", i, dut_vec(), exp_vec());
      end
    end
    bus.ack_a = 1'b0; bus.ack_b = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      bus.sen_a_n = i[0]; bus.sen_b_n = ~i[1];
      step();
      checks++;
      if (dut_vec() !== 4'b0000) begin
        errors++;
        $display("FAIL reset_hold cyc %0d got %b want 0000", i, dut_vec());
      end
    end
    bus.sen_a_n = 1'b1; bus.sen_b_n = 1'b1;
    reset_n = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      step();
      checks++;
      if ((bus.tick_o !== ((i % TDIV) == TDIV - 1)) || (bus.hb_o !== ((i % TDIV) >= TDIV / 2))) begin
        errors++;
        $display("FAIL tick_hb cyc %0d got tick=%b hb=%b", i, bus.tick_o, bus.hb_o);
      end
    end
  endtask

  task automatic test_press_latency();
    settle();
    bus.sen_a_n = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      checks++;
      if (bus.ta_o !== (i >= SS + DEB) || bus.tb_o !== 1'b0) begin
        errors++;
        $display("FAIL press_lat cyc %0d got ta=%b tb=%b want ta=%b tb=0", i, bus.ta_o, bus.tb_o, (i >= SS + DEB));
      end
    end
  endtask

  task automatic test_glitch();
    // Pattern: short press (3 low), then long press, then bounce while releasing
    bit pat [];
    pat = '{0,0,0,1,1,1,1,1,1,1, 0,0,0,0,0,0,0,0,0, 1,1,0,1,1,1,0, 1,1,1,1,1,1,1,1};
    settle();
    for (int i = 0; i < pat.size(); i++) begin
      bus.sen_a_n = pat[i];
      step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL glitch cyc %0d got %b want %b", i, dut_vec(), exp_vec());
      end
      if (i < 10 || (i >= 19 && i <= 27)) begin
        checks++;
        if (bus.ta_o !== (i >= 10)) begin
          errors++;
          $display("FAIL glitch_level cyc %0d got ta=%b want %b", i, bus.ta_o, (i >= 10));
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    settle();
    bus.sen_a_n = 1'b0; bus.sen_b_n = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      checks++;
      if (bus.ta_o !== (i >= SS + DEB) || bus.tb_o !== (i >= SS + DEB)) begin
        errors++;
        $display("FAIL simul cyc %0d got ta=%b tb=%b want %b", i, bus.ta_o, bus.tb_o, (i >= SS + DEB));
      end
    end
  endtask

  task automatic test_sticky();
`ifdef STICKY_REQ_EN
    settle();
    bus.sen_a_n = 1'b0;
    for (int i = 0; i < 10; i++) step();
    bus.sen_a_n = 1'b1;
    for (int i = 0; i < 10; i++) step();
    checks++;
    if (bus.ta_o !== 1'b1) begin
      errors++;
      $display("FAIL sticky_hold got %b want 1", bus.ta_o);
    end
    bus.ack_a = 1'b1;
    step();
    bus.ack_a = 1'b0;
    checks++;
    if (bus.ta_o !== 1'b0) begin
      errors++;
      $display("FAIL sticky_ack got %b want 0", bus.ta_o);
    end
    bus.sen_a_n = 1'b0;
    for (int i = 1; i <= SS + DEB; i++) begin
      bus.ack_a = (i == SS + DEB);
      step();
    end
    bus.ack_a = 1'b0;
    checks++;
    if (bus.ta_o !== 1'b1) begin
      errors++;
      $display("FAIL sticky_set_wins got %b want 1", bus.ta_o);
    end
    step();
    checks++;
    if (bus.ta_o !== 1'b1) begin
      errors++;
      $display("FAIL sticky_after_coincide got %b want 1", bus.ta_o);
    end
`endif
  endtask

  task automatic test_reset_midway();
    settle();
    bus.sen_a_n = 1'b0;
    for (int i = 0; i < SS + 1; i++) step();
    reset_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (dut_vec() !== 4'b0000) begin
      errors++;
      $display("FAIL reset_async got %b want 0000", dut_vec());
    end
    step();
    step();
    reset_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      checks++;
      if (bus.ta_o !== (i >= SS + DEB) || dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reset_relat cyc %0d got %b want %b", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    int len_a = 0;
    int len_b = 0;
    settle();
    for (int i = 0; i < 600; i++) begin
      if (len_a == 0) begin
        bus.sen_a_n = ~bus.sen_a_n;
        len_a = $urandom_range(1, 8);
      end
      if (len_b == 0) begin
        bus.sen_b_n = ~bus.sen_b_n;
        len_b = $urandom_range(1, 8);
      end
      len_a--; len_b--;
      bus.ack_a = ($urandom_range(0, 7) == 0);
      bus.ack_b = ($urandom_range(0, 7) == 0);
      step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc %0d got %b want %b", i, dut_vec(), exp_vec());
      end
    end
    bus.ack_a = 1'b0; bus.ack_b = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    bus.sen_a_n = 1'b1; bus.sen_b_n = 1'b1;
    bus.ack_a = 1'b0;   bus.ack_b = 1'b0;
    model_reset();
    test_reset();
    test_press_latency();
    test_glitch();
    test_simultaneous();
    test_sticky();
    test_reset_midway();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
